// File: rtl/sll_seq.sv
// Multi-cycle 32-bit logical left shifter: one barrel stage (shift by 2^k) per clock,
// valid/ready on both sides, and a sticky flag for non-zero bits pushed past the MSB.
module sll_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             lost,
    output logic             busy
);

    localparam int unsigned KW = (SHW > 1) ? $clog2(SHW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(SHW - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             w_in_ready_nxt;
    logic             w_out_valid_nxt;
    logic             w_busy_nxt;

    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_amt;
    logic [KW-1:0]    r_k;
    logic             r_lost;

    logic             w_accept;
    logic             w_step;
    logic             w_last;
    logic             w_amt_bit;
    logic [WIDTH-1:0] w_sel_acc;
    logic             w_sel_lost;

    logic [WIDTH-1:0] w_stage_acc  [SHW];
    logic             w_stage_lost [SHW];

    // Every candidate stage result, precomputed from the accumulator.
    for (genvar s = 0; s < SHW; s++) begin : g_stage
        localparam int unsigned SH = 1 << s;
        assign w_stage_acc[s]  = {r_acc[WIDTH-1-SH:0], {SH{1'b0}}};
        assign w_stage_lost[s] = |r_acc[WIDTH-1 -: SH];
    end

    // Pick the stage selected by the counter.
    always_comb begin
        w_sel_acc  = r_acc;
        w_sel_lost = 1'b0;
        w_amt_bit  = 1'b0;
        for (int unsigned s = 0; s < SHW; s++) begin
            if (r_k == KW'(s)) begin
                w_sel_acc  = w_stage_acc[s];
                w_sel_lost = w_stage_lost[s];
                w_amt_bit  = r_amt[s];
            end
        end
    end

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_step   = (r_state == S_SHIFT);
    assign w_last   = (r_k == K_LAST);

    // State register and registered handshake/status flags.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
            S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Flags follow the upcoming state so they are valid straight from a flop.
    always_comb begin
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        case (w_state_nxt)
            S_IDLE:  w_in_ready_nxt  = 1'b1;
            S_SHIFT: w_busy_nxt      = 1'b1;
            S_DONE: begin
                w_out_valid_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            default: w_in_ready_nxt  = 1'b1;
        endcase
    end

    // Datapath: capture on accept, then one conditional stage per SHIFT cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_acc  <= '0;
            r_amt  <= '0;
            r_k    <= '0;
            r_lost <= 1'b0;
        end else if (w_accept) begin
            r_acc  <= data_in;
            r_amt  <= shamt;
            r_k    <= '0;
            r_lost <= 1'b0;
        end else if (w_step) begin
            if (w_amt_bit) begin
                r_acc  <= w_sel_acc;
                r_lost <= r_lost | w_sel_lost;
            end
            r_k <= w_last ? '0 : r_k + KW'(1);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign data_out  = r_acc;
    assign lost      = r_lost;

endmodule

// File: tb/tb_sll_seq.sv
// Self-checking bench for sll_seq: directed cases with literal expectations plus
// randomized traffic checked every cycle against a transaction-level reference.
module tb_sll_seq;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SHW   = 5;
    localparam int          LAT   = 5;

    logic             clock     = 1'b0;
    logic             resetn    = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] data_in   = '0;
    logic [SHW-1:0]   shamt     = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             lost;
    logic             busy;

    int checks = 0;
    int errors = 0;

    sll_seq #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .lost      (lost),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result: widen, shift, split into kept word and discarded bits.
    task automatic ref_shift(input logic [31:0] d, input logic [4:0] s,
                             output logic [31:0] r, output logic l);
        logic [63:0] w;
        w = {32'd0, d} << s;
        r = w[31:0];
        l = |w[63:32];
    endtask

    // Transaction-level model: one operation in flight, result due LAT edges after accept.
    bit          m_op    = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_known = 1'b1;
    bit          m_pre_valid;
    int          m_acc   = 0;
    int          cyc     = 0;
    logic [31:0] m_data  = '0;
    logic        m_lost  = 1'b0;

    always @(posedge clock) begin
        m_pre_valid = m_valid;
        cyc++;
        if (!resetn) begin
            m_op    = 1'b0;
            m_known = 1'b1;
            m_data  = '0;
            m_lost  = 1'b0;
        end else if (m_pre_valid && out_ready) begin
            m_op = 1'b0;
        end else if (!m_op && in_valid) begin
            m_op    = 1'b1;
            m_acc   = cyc;
            m_known = 1'b0;
            ref_shift(data_in, shamt, m_data, m_lost);
        end
        m_valid = m_op && ((cyc - m_acc) >= LAT);
        if (m_valid) m_known = 1'b1;
        #1;
        check("in_ready", 32'(in_ready), 32'(!m_op));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_op));
        if (m_known) begin
            check("data_out", data_out, m_data);
            check("lost", 32'(lost), 32'(m_lost));
        end
    end

    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        ok = in_ready;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: in_ready stayed %0b for %0d cycles", in_ready, n);
        end
    endtask

    task automatic offer(input logic [31:0] d, input logic [4:0] s);
        in_valid = 1'b1;
        data_in  = d;
        shamt    = s;
        @(negedge clock);
        in_valid = 1'b0;
        data_in  = $urandom;
        shamt    = 5'($urandom);
    endtask

    task automatic run_op(input logic [31:0] d, input logic [4:0] s,
                          input logic [31:0] ed, input logic el, input string tag);
        int n = 0;
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        offer(d, s);
        while (!out_valid && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(LAT));
        check({tag, "_data"}, data_out, ed);
        check({tag, "_lost"}, 32'(lost), 32'(el));
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        repeat (2) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        resetn = 1'b1;
        @(negedge clock);

        run_op(32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, "msb");
        run_op(32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, 1'b1, "ones");
        run_op(32'h8000_0001, 5'd16, 32'h0001_0000, 1'b1, "half");
        run_op(32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, "zero");

        // Backpressure: result held in DONE while new operands are offered.
        wait_ready(ok);
        offer(32'hF0F0_F0F1, 5'd3);
        for (int n = 0; n < 20 && !out_valid; n++) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            data_in  = $urandom;
            shamt    = 5'($urandom);
            @(negedge clock);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_ready", 32'(in_ready), 32'd0);
            check("bp_data", data_out, 32'h8787_8788);
            check("bp_lost", 32'(lost), 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        check("bp_ready_after", 32'(in_ready), 32'd1);
        check("bp_not_accepted", 32'(busy), 32'd0);
        check("bp_data_held", data_out, 32'h8787_8788);

        // Reset two cycles into an operation.
        wait_ready(ok);
        offer(32'hA5A5_A5A5, 5'd8);
        repeat (2) @(negedge clock);
        resetn = 1'b0;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'd0);
        check("mr_data_out", data_out, 32'd0);
        check("mr_lost", 32'(lost), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("mr_in_ready", 32'(in_ready), 32'd1);
        run_op(32'hA5A5_A5A5, 5'd8, 32'hA5A5_A500, 1'b1, "mr_next");

        // Randomized traffic, including occasional resets.
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 3))
                0:       data_in = 32'd1 << $urandom_range(0, 31);
                1:       data_in = 32'hFFFF_FFFF;
                default: data_in = $urandom;
            endcase
            shamt     = 5'($urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            resetn    = ($urandom_range(0, 199) != 0);
            @(negedge clock);
        end
        resetn    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
